// File: rtl/cpu_mem_pkg.sv
// ---------------------------------------------------------------------------
// cpu_mem_pkg
//   Shared definitions for the 16-bit cpu memory subsystem.
//   - MEM_* codes for the data-port command (a_ctrl)
//   - boot sequencer state type
//   - default word width shared by the top and the read pipeline
//   - small decode helper for data-port commands
// ---------------------------------------------------------------------------
package cpu_mem_pkg;

    // Default word width of both memory ports and the boot stream.
    localparam int DATA_W_DEF = 16;

    // Data-port command codes (a_ctrl).
    localparam logic [1:0] MEM_IDLE  = 2'b00;
    localparam logic [1:0] MEM_READ  = 2'b01;
    localparam logic [1:0] MEM_WRITE = 2'b10;
    localparam logic [1:0] MEM_RSVD  = 2'b11;

    // Boot sequencer: LOAD streams the program in, RUN is terminal until reset.
    typedef enum logic [0:0] {
        BOOT_LOAD = 1'b0,
        BOOT_RUN  = 1'b1
    } bootState_t;

    // True for the two commands that actually touch the storage array.
    function automatic logic ctrlAccessesMem(input logic [1:0] ctrl);
        return (ctrl == MEM_READ) || (ctrl == MEM_WRITE);
    endfunction

endpackage

// File: rtl/mem_read_pipe.sv
// ---------------------------------------------------------------------------
// mem_read_pipe
//   Registered delay line for one memory read port. A word presented with
//   inValid=1 appears on outData RD_LAT rising edges later. outData keeps its
//   last value while no new read arrives, so a port that reads only on request
//   (data port) holds its load result, and a port that reads every cycle
//   (fetch port) simply streams.
//
// Ports
//   clk      in   1        rising-edge clock
//   rst      in   1        asynchronous active-high reset, clears every stage
//   inValid  in   1        inData carries a read result this cycle
//   inData   in   DATA_W   raw read result from the storage array
//   outData  out  DATA_W   delayed, held read result
// ---------------------------------------------------------------------------
module mem_read_pipe
    import cpu_mem_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inValid,
    input  logic [DATA_W-1:0] inData,
    output logic [DATA_W-1:0] outData
);

    generate
        if (RD_LAT <= 1) begin : gDirect
            // Single stage: the output register itself is the only delay.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    outData <= '0;
                end else if (inValid) begin
                    outData <= inData;
                end
            end
        end else begin : gStaged
            // RD_LAT-1 plain shift stages carry data plus a valid flag; only the
            // final output register holds when no valid word reaches it.
            logic [RD_LAT-2:0] stageVld;
            logic [DATA_W-1:0] stageData [RD_LAT-1];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    stageVld <= '0;
                    for (int i = 0; i < RD_LAT - 1; i++) begin
                        stageData[i] <= '0;
                    end
                    outData <= '0;
                end else begin
                    stageVld[0]  <= inValid;
                    stageData[0] <= inData;
                    for (int i = 1; i < RD_LAT - 1; i++) begin
                        stageVld[i]  <= stageVld[i-1];
                        stageData[i] <= stageData[i-1];
                    end
                    if (stageVld[RD_LAT-2]) begin
                        outData <= stageData[RD_LAT-2];
                    end
                end
            end
        end
    endgenerate

endmodule

// File: rtl/boot_dual_mem.sv
// ---------------------------------------------------------------------------
// boot_dual_mem
//   Dual-port memory for the 16-bit pipelined cpu with a built-in boot loader.
//   Port B is instruction fetch (reads every cycle), port A is data
//   load/store. After reset the block (when BOOT_EN=1) accepts a program over
//   a valid/ready stream and holds the cpu stalled; once the last word (or the
//   word at DEPTH-1) is accepted it enters RUN for good.
//
// Ports
//   clk         in   1       rising-edge clock
//   rst         in   1       asynchronous reset, active-high
//   load_valid  in   1       boot word present on load_data
//   load_data   in   DATA_W  boot word
//   load_last   in   1       marks the final boot word
//   load_ready  out  1       loader accepts a word this cycle
//   boot_done   out  1       high once in RUN
//   cpu_stall   out  1       holds the cpu pipeline while not in RUN
//   b_addr      in   ADDR_W  instruction fetch address
//   b_rdata     out  DATA_W  instruction word, RD_LAT cycles after b_addr
//   a_addr      in   ADDR_W  data address
//   a_wdata     in   DATA_W  store data
//   a_ctrl      in   2       MEM_IDLE / MEM_READ / MEM_WRITE / MEM_RSVD
//   a_rdata     out  DATA_W  load data, RD_LAT cycles after a read request
//   err         out  1       sticky: reserved command or out-of-range access
//                            on either port while in RUN
// ---------------------------------------------------------------------------
module boot_dual_mem
    import cpu_mem_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ADDR_W  = 16,
    parameter int DEPTH   = 1024,
    parameter int RD_LAT  = 1,
    parameter int BOOT_EN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_ready,
    output logic              boot_done,
    output logic              cpu_stall,
    input  logic [ADDR_W-1:0] b_addr,
    output logic [DATA_W-1:0] b_rdata,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    input  logic [1:0]        a_ctrl,
    output logic [DATA_W-1:0] a_rdata,
    output logic              err
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // DEPTH widened by one bit so the range compare is exact even when DEPTH
    // equals 2**ADDR_W.
    localparam logic [ADDR_W:0]  DEPTH_X  = (ADDR_W + 1)'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    bootState_t        state;
    logic [PTR_W-1:0]  loadPtr;
    logic              loadReady;
    logic              errReg;

    logic [DATA_W-1:0] mem [DEPTH];

    // -----------------------------------------------------------------------
    // Decode
    // -----------------------------------------------------------------------
    logic              isRun;
    logic              loadFire;
    logic              loadEnd;
    logic              bInRange;
    logic              aInRange;
    logic [PTR_W-1:0]  bIdx;
    logic [PTR_W-1:0]  aIdx;
    logic              aRead;
    logic              aWrite;
    logic              errEvent;
    logic [DATA_W-1:0] bRaw;
    logic [DATA_W-1:0] aRaw;

    assign isRun    = (state == BOOT_RUN);
    assign loadFire = !isRun && load_valid && loadReady;
    // Leaving LOAD on the word at DEPTH-1 means the pointer never wraps.
    assign loadEnd  = load_last || (loadPtr == PTR_LAST);

    assign bInRange = {1'b0, b_addr} < DEPTH_X;
    assign aInRange = {1'b0, a_addr} < DEPTH_X;
    assign bIdx     = b_addr[PTR_W-1:0];
    assign aIdx     = a_addr[PTR_W-1:0];

    assign aRead    = isRun && (a_ctrl == MEM_READ);
    assign aWrite   = isRun && (a_ctrl == MEM_WRITE) && aInRange;

    // The fetch port reads every cycle, so a wild nextPC is flagged as well.
    assign errEvent = isRun && (!bInRange
                                || (a_ctrl == MEM_RSVD)
                                || (ctrlAccessesMem(a_ctrl) && !aInRange));

    // Combinational array read ahead of the pipeline registers. Because the
    // write below lands at the clock edge, a same-cycle write to the address
    // being read returns the old word (read-first).
    always_comb begin
        // NOTE: every signal written in always_comb gets a default first so no
        // path leaves it unassigned, which would infer a latch.
        bRaw = '0;
        aRaw = '0;
        if (bInRange) begin
            bRaw = mem[bIdx];
        end
        if (aInRange) begin
            aRaw = mem[aIdx];
        end
    end

    // -----------------------------------------------------------------------
    // Boot sequencer, load pointer and sticky error
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            state     <= (BOOT_EN != 0) ? BOOT_LOAD : BOOT_RUN;
            loadPtr   <= '0;
            loadReady <= 1'b0;
            errReg    <= 1'b0;
        end else begin
            case (state)
                BOOT_LOAD: begin
                    loadReady <= 1'b1;
                    if (loadFire) begin
                        loadPtr <= loadPtr + 1'b1;
                        if (loadEnd) begin
                            state     <= BOOT_RUN;
                            loadReady <= 1'b0;
                        end
                    end
                end
                BOOT_RUN: begin
                    loadReady <= 1'b0;
                    if (errEvent) begin
                        errReg <= 1'b1;
                    end
                end
                default: begin
                    state     <= BOOT_RUN;
                    loadReady <= 1'b0;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Storage array. Loader and data port never write in the same cycle: the
    // loader is only active in LOAD, the data port only in RUN.
    // -----------------------------------------------------------------------
    // NOTE: the array has no reset; clearing every word would block RAM
    // inference, and its contents are defined only once written.
    always_ff @(posedge clk) begin
        if (loadFire) begin
            mem[loadPtr] <= load_data;
        end else if (aWrite) begin
            mem[aIdx] <= a_wdata;
        end
    end

    // -----------------------------------------------------------------------
    // Read pipelines. No valid words enter during LOAD, so both outputs stay
    // at their reset value of zero until the cpu runs.
    // -----------------------------------------------------------------------
    mem_read_pipe #(
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) uFetchPipe (
        .clk     (clk),
        .rst     (rst),
        .inValid (isRun),
        .inData  (bRaw),
        .outData (b_rdata)
    );

    mem_read_pipe #(
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) uDataPipe (
        .clk     (clk),
        .rst     (rst),
        .inValid (aRead),
        .inData  (aRaw),
        .outData (a_rdata)
    );

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign load_ready = loadReady;
    assign boot_done  = isRun;
    assign cpu_stall  = !isRun;
    assign err        = errReg;

endmodule

// File: tb/tb_boot_dual_mem.sv
// ---------------------------------------------------------------------------
// tb_boot_dual_mem
//   Three instances share clock and reset:
//     u0: defaults (DEPTH=1024, RD_LAT=1, BOOT_EN=1)
//     u1: DEPTH=16, RD_LAT=2, BOOT_EN=1 (boot ends at DEPTH-1 without last)
//     u2: DEPTH=16, RD_LAT=2, BOOT_EN=0 (runs straight out of reset)
//   A behavioural model (word array, boot flag, per-edge read history) runs
//   beside them; every falling edge compares all outputs against it, and
//   directed steps add literal checks for the documented scenarios.
// ---------------------------------------------------------------------------
module tb_boot_dual_mem;
    import cpu_mem_pkg::*;

    localparam int NI = 3;

    function automatic int depthOf(input int i);
        return (i == 0) ? 1024 : 16;
    endfunction

    function automatic int latOf(input int i);
        return (i == 0) ? 1 : 2;
    endfunction

    function automatic bit bootOf(input int i);
        return (i == 2) ? 1'b0 : 1'b1;
    endfunction

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        loadValid [NI];
    logic [15:0] loadData  [NI];
    logic        loadLast  [NI];
    logic        loadReady [NI];
    logic        bootDone  [NI];
    logic        cpuStall  [NI];
    logic [15:0] bAddr     [NI];
    logic [15:0] bRdata    [NI];
    logic [15:0] aAddr     [NI];
    logic [15:0] aWdata    [NI];
    logic [1:0]  aCtrl     [NI];
    logic [15:0] aRdata    [NI];
    logic        err       [NI];

    boot_dual_mem u0 (
        .clk(clk), .rst(rst),
        .load_valid(loadValid[0]), .load_data(loadData[0]), .load_last(loadLast[0]),
        .load_ready(loadReady[0]), .boot_done(bootDone[0]), .cpu_stall(cpuStall[0]),
        .b_addr(bAddr[0]), .b_rdata(bRdata[0]),
        .a_addr(aAddr[0]), .a_wdata(aWdata[0]), .a_ctrl(aCtrl[0]), .a_rdata(aRdata[0]),
        .err(err[0])
    );

    boot_dual_mem #(.DEPTH(16), .RD_LAT(2), .BOOT_EN(1)) u1 (
        .clk(clk), .rst(rst),
        .load_valid(loadValid[1]), .load_data(loadData[1]), .load_last(loadLast[1]),
        .load_ready(loadReady[1]), .boot_done(bootDone[1]), .cpu_stall(cpuStall[1]),
        .b_addr(bAddr[1]), .b_rdata(bRdata[1]),
        .a_addr(aAddr[1]), .a_wdata(aWdata[1]), .a_ctrl(aCtrl[1]), .a_rdata(aRdata[1]),
        .err(err[1])
    );

    boot_dual_mem #(.DEPTH(16), .RD_LAT(2), .BOOT_EN(0)) u2 (
        .clk(clk), .rst(rst),
        .load_valid(loadValid[2]), .load_data(loadData[2]), .load_last(loadLast[2]),
        .load_ready(loadReady[2]), .boot_done(bootDone[2]), .cpu_stall(cpuStall[2]),
        .b_addr(bAddr[2]), .b_rdata(bRdata[2]),
        .a_addr(aAddr[2]), .a_wdata(aWdata[2]), .a_ctrl(aCtrl[2]), .a_rdata(aRdata[2]),
        .err(err[2])
    );

    // ---------------------------------------------------------------- model
    typedef struct {
        bit          v;
        bit          known;
        logic [15:0] d;
    } rdEntry_t;

    logic [15:0] mMem   [NI][1024];
    bit          mKnown [NI][1024];
    bit          mRun   [NI];
    bit          mReady [NI];
    bit          mErr   [NI];
    int          mPtr   [NI];
    rdEntry_t    bHist  [NI][2];
    rdEntry_t    aHist  [NI][2];
    logic [15:0] expB   [NI];
    logic [15:0] expA   [NI];
    bit          expBKnown [NI];
    bit          expAKnown [NI];

    int total  = 0;
    int passed = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic modelReset(input int i);
        mRun[i]   = !bootOf(i);
        mReady[i] = 1'b0;
        mErr[i]   = 1'b0;
        mPtr[i]   = 0;
        for (int k = 0; k < 2; k++) begin
            bHist[i][k] = '{v: 1'b0, known: 1'b1, d: 16'h0};
            aHist[i][k] = '{v: 1'b0, known: 1'b1, d: 16'h0};
        end
        expB[i] = 16'h0; expBKnown[i] = 1'b1;
        expA[i] = 16'h0; expAKnown[i] = 1'b1;
    endtask

    // One rising edge of instance i, computed from the inputs it sampled.
    task automatic modelEdge(input int i);
        rdEntry_t nb, na, pick;
        int d;
        d  = depthOf(i);
        nb = '{v: 1'b0, known: 1'b1, d: 16'h0};
        na = nb;
        if (!mRun[i]) begin
            if (loadValid[i] && mReady[i]) begin
                mMem[i][mPtr[i]]   = loadData[i];
                mKnown[i][mPtr[i]] = 1'b1;
                if (loadLast[i] || mPtr[i] == d - 1) mRun[i] = 1'b1;
                mPtr[i]++;
            end
            mReady[i] = !mRun[i];
        end else begin
            mReady[i] = 1'b0;
            nb.v = 1'b1;
            if (int'(bAddr[i]) < d) begin
                nb.known = mKnown[i][bAddr[i]];
                nb.d     = mMem[i][bAddr[i]];
            end else begin
                mErr[i] = 1'b1;
            end
            case (aCtrl[i])
                MEM_READ: begin
                    na.v = 1'b1;
                    if (int'(aAddr[i]) < d) begin
                        na.known = mKnown[i][aAddr[i]];
                        na.d     = mMem[i][aAddr[i]];
                    end else begin
                        mErr[i] = 1'b1;
                    end
                end
                MEM_WRITE: begin
                    if (int'(aAddr[i]) < d) begin
                        mMem[i][aAddr[i]]   = aWdata[i];
                        mKnown[i][aAddr[i]] = 1'b1;
                    end else begin
                        mErr[i] = 1'b1;
                    end
                end
                MEM_RSVD: mErr[i] = 1'b1;
                default: ;
            endcase
        end
        bHist[i][1] = bHist[i][0]; bHist[i][0] = nb;
        aHist[i][1] = aHist[i][0]; aHist[i][0] = na;
        pick = bHist[i][latOf(i) - 1];
        if (pick.v) begin expB[i] = pick.d; expBKnown[i] = pick.known; end
        pick = aHist[i][latOf(i) - 1];
        if (pick.v) begin expA[i] = pick.d; expAKnown[i] = pick.known; end
    endtask

    task automatic checkAll();
        for (int i = 0; i < NI; i++) begin
            check($sformatf("u%0d.load_ready", i), 32'(loadReady[i]), 32'(mReady[i]));
            check($sformatf("u%0d.boot_done", i),  32'(bootDone[i]),  32'(mRun[i]));
            check($sformatf("u%0d.cpu_stall", i),  32'(cpuStall[i]),  32'(!mRun[i]));
            check($sformatf("u%0d.err", i),        32'(err[i]),       32'(mErr[i]));
            if (expBKnown[i]) check($sformatf("u%0d.b_rdata", i), 32'(bRdata[i]), 32'(expB[i]));
            if (expAKnown[i]) check($sformatf("u%0d.a_rdata", i), 32'(aRdata[i]), 32'(expA[i]));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst) begin
            for (int i = 0; i < NI; i++) modelEdge(i);
        end
        @(negedge clk);
        checkAll();
    endtask

    task automatic setIdle(input int i);
        loadValid[i] = 1'b0; loadData[i] = 16'h0; loadLast[i] = 1'b0;
        bAddr[i] = 16'h0; aAddr[i] = 16'h0; aWdata[i] = 16'h0; aCtrl[i] = MEM_IDLE;
    endtask

    task automatic randomOps(input int i, input int maxAddr);
        bAddr[i]  = 16'($urandom_range(0, maxAddr));
        aAddr[i]  = 16'($urandom_range(0, maxAddr));
        aWdata[i] = 16'($urandom);
        aCtrl[i]  = 2'($urandom_range(0, 2));
    endtask

    // Reset asserted between edges; outputs must clear immediately.
    task automatic pulseReset();
        #2 rst = 1'b1;
        #1;
        for (int i = 0; i < NI; i++) modelReset(i);
        checkAll();
        for (int i = 0; i < NI; i++) setIdle(i);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // ---------------------------------------------------------------- stimulus
    initial begin
        for (int i = 0; i < NI; i++) setIdle(i);
        rst = 1'b1;
        #1;
        for (int i = 0; i < NI; i++) modelReset(i);
        checkAll();
        check("reset u0 cpu_stall", 32'(cpuStall[0]), 32'd1);
        check("reset u2 cpu_stall", 32'(cpuStall[2]), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Partial boot of u0/u1, then abort with reset mid-load.
        tick();
        check("u0 load_ready after release", 32'(loadReady[0]), 32'd1);
        for (int k = 0; k < 2; k++) begin
            loadValid[0] = 1'b1; loadData[0] = 16'hA000 + 16'(k);
            loadValid[1] = 1'b1; loadData[1] = 16'hB000 + 16'(k);
            randomOps(2, 15);
            tick();
        end
        pulseReset();
        check("midload rst u0 load_ready", 32'(loadReady[0]), 32'd0);
        check("midload rst u1 boot_done", 32'(bootDone[1]), 32'd0);

        // Full boot: u0 three words with a two-cycle gap, u1 16 words, no last.
        tick();
        for (int k = 0; k < 17; k++) begin
            loadLast[0] = 1'b0;
            loadValid[0] = 1'b0;
            aCtrl[0] = (k < 4) ? MEM_RSVD : MEM_IDLE;
            case (k)
                0: begin loadValid[0] = 1'b1; loadData[0] = 16'h0000; end
                1: begin loadValid[0] = 1'b1; loadData[0] = 16'h0800; end
                4: begin loadValid[0] = 1'b1; loadData[0] = 16'h1044; loadLast[0] = 1'b1; end
                default: ;
            endcase
            bAddr[0] = (k >= 5) ? 16'd2 : 16'd7;
            loadValid[1] = 1'b1;
            loadData[1]  = 16'($urandom);
            loadLast[1]  = 1'b0;
            if (k < 15) randomOps(1, 15);
            else begin bAddr[1] = 16'd15; aCtrl[1] = MEM_IDLE; end
            loadValid[2] = 1'($urandom_range(0, 1));
            randomOps(2, 15);
            tick();
            if (k == 3) check("u0 boot_done before last", 32'(bootDone[0]), 32'd0);
            if (k == 4) begin
                check("u0 load_ready after last", 32'(loadReady[0]), 32'd0);
                check("u0 boot_done after last", 32'(bootDone[0]), 32'd1);
                check("u0 err ignored in load", 32'(err[0]), 32'd0);
            end
            if (k == 5)  check("u0 fetch @2", 32'(bRdata[0]), 32'h1044);
            if (k == 14) check("u1 boot_done before depth-1", 32'(bootDone[1]), 32'd0);
            if (k == 15) check("u1 boot_done at depth-1", 32'(bootDone[1]), 32'd1);
        end
        loadValid[1] = 1'b0;
        loadValid[2] = 1'b0;

        // Write-then-read and read-first on u0.
        aCtrl[0] = MEM_WRITE; aAddr[0] = 16'd5; aWdata[0] = 16'h1234; bAddr[0] = 16'd2;
        randomOps(1, 15); randomOps(2, 15);
        tick();
        aCtrl[0] = MEM_WRITE; aAddr[0] = 16'd5; aWdata[0] = 16'hBEEF; bAddr[0] = 16'd5;
        randomOps(1, 15); randomOps(2, 15);
        tick();
        check("u0 read-first fetch @5", 32'(bRdata[0]), 32'h1234);
        aCtrl[0] = MEM_READ; aAddr[0] = 16'd5;
        randomOps(1, 15); randomOps(2, 15);
        tick();
        check("u0 a_rdata @5", 32'(aRdata[0]), 32'hBEEF);
        check("u0 fetch @5 new", 32'(bRdata[0]), 32'hBEEF);
        aCtrl[0] = MEM_IDLE; bAddr[0] = 16'd0;
        tick();
        check("u0 a_rdata hold", 32'(aRdata[0]), 32'hBEEF);
        check("u0 err clean", 32'(err[0]), 32'd0);

        // Out-of-range and reserved commands.
        aCtrl[0] = MEM_WRITE; aAddr[0] = 16'd1024; aWdata[0] = 16'h5555;
        aCtrl[2] = MEM_RSVD;
        bAddr[1] = 16'd16; aCtrl[1] = MEM_IDLE;
        tick();
        check("u0 err oor write", 32'(err[0]), 32'd1);
        check("u2 err rsvd", 32'(err[2]), 32'd1);
        check("u1 err fetch oor", 32'(err[1]), 32'd1);
        aCtrl[0] = MEM_READ; aAddr[0] = 16'd1024; aCtrl[2] = MEM_IDLE; bAddr[1] = 16'd3;
        tick();
        check("u0 a_rdata oor", 32'(aRdata[0]), 32'h0);
        aCtrl[0] = MEM_READ; aAddr[0] = 16'd5;
        tick();
        aCtrl[0] = MEM_IDLE;
        for (int k = 0; k < 3; k++) tick();
        check("u0 err sticky", 32'(err[0]), 32'd1);
        check("u0 oor write dropped", 32'(aRdata[0]), 32'hBEEF);
        check("u0 word0 intact", 32'(bRdata[0]), 32'h0000);

        // Random traffic on all instances.
        for (int k = 0; k < 150; k++) begin
            randomOps(0, 7);
            randomOps(1, 15);
            randomOps(2, 15);
            tick();
        end

        pulseReset();
        check("final rst u0 err", 32'(err[0]), 32'd0);
        check("final rst u2 cpu_stall", 32'(cpuStall[2]), 32'd0);
        check("final rst u0 boot_done", 32'(bootDone[0]), 32'd0);
        tick();
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
